// File: rtl/road_pkg.sv
// Shared types and helpers for the Road Fighter game-state engine.
//   state_t   : game FSM states
//   NUM_CARS  : number of enemy cars
//   LFSR_SEED : reset value of the spawn generator
//   lane_x()  : x coordinate of an enemy lane
package road_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_t;

  localparam int unsigned NUM_CARS  = 5;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  // Lane x of car idx: road_min + idx * lane_w, truncated to the 8-bit screen range.
  function automatic logic [7:0] lane_x(input int unsigned road_min,
                                        input int unsigned lane_w,
                                        input int unsigned idx);
    return 8'(road_min + idx * lane_w);
  endfunction

endpackage

// File: rtl/car_motion_ctrl_lfsr8.sv
// 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1) used to pick spawn lanes.
//   clk, reset : clock, async active-high reset (loads LFSR_SEED)
//   q          : current LFSR state, advances every clock
module lfsr8
  import road_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  // Fibonacci form; a non-zero seed can never reach the all-zero lock-up state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// Per-frame game-state engine: player movement, enemy advance/spawn,
// collision detection and scoring.
//   clk, reset                  : clock, async active-high reset
//   frame_tick                  : one pulse per frame (vertical blank start)
//   btn_left/right/start        : raw asynchronous push-buttons
//   player_x                    : player car x
//   car_y_0..car_y_4            : enemy car y positions
//   car_active                  : enemy valid bits
//   crash / running             : high in CRASH / RUN
//   score                       : cars passed, saturating
// Build option: ROAD_SPEEDUP_EN makes the enemy step grow with score.
module car_motion_ctrl
  import road_pkg::*;
#(
  parameter int unsigned ROAD_MIN     = 40,
  parameter int unsigned ROAD_MAX     = 200,
  parameter int unsigned LANE_W       = 32,
  parameter int unsigned PLAYER_X0    = 120,
  parameter int unsigned PLAYER_Y     = 200,
  parameter int unsigned PLAYER_STEP  = 2,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned Y_MAX        = 239,
  parameter int unsigned CAR_W        = 16,
  parameter int unsigned CAR_H        = 24,
  parameter int unsigned CRASH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [7:0]  player_x,
  output logic [7:0]  car_y_0,
  output logic [7:0]  car_y_1,
  output logic [7:0]  car_y_2,
  output logic [7:0]  car_y_3,
  output logic [7:0]  car_y_4,
  output logic [4:0]  car_active,
  output logic        crash,
  output logic        running,
  output logic [15:0] score
);

  localparam int unsigned CNT_W = $clog2(CRASH_FRAMES + 1);

  state_t             state;
  logic [2:0]         btn_meta;
  logic [2:0]         btn_sync;
  logic               start_d;
  logic [CNT_W-1:0]   crash_cnt;
  logic [7:0]         car_y [NUM_CARS];
  logic [7:0]         lfsr_q;

  logic               start_edge;
  logic [NUM_CARS-1:0] hit_vec;
  logic [NUM_CARS-1:0] retire_vec;
  logic [NUM_CARS-1:0] spawn_vec;
  logic [8:0]         y_adv [NUM_CARS];
  logic [8:0]         step;
  logic [7:0]         px_next;
  logic [2:0]         retire_cnt;
  logic [16:0]        score_sum;
  logic [15:0]        score_next;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign car_y_0 = car_y[0];
  assign car_y_1 = car_y[1];
  assign car_y_2 = car_y[2];
  assign car_y_3 = car_y[3];
  assign car_y_4 = car_y[4];

  // btn_sync = {start, right, left} after two flops; start_d is the edge-detect delay.
  assign start_edge = btn_sync[2] & ~start_d;

`ifdef ROAD_SPEEDUP_EN
  // Enemy step grows with score[7:4], capped at four times the base speed.
  logic [8:0] step_raw;
  assign step_raw = 9'(SPEED) + 9'(score[7:4]);
  assign step     = (step_raw > 9'(4 * SPEED)) ? 9'(4 * SPEED) : step_raw;
`else
  assign step = 9'(SPEED);
`endif

  // Per-car collision test and advanced position, in 9-bit arithmetic.
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    localparam logic [7:0] LX = lane_x(ROAD_MIN, LANE_W, g);
    logic signed [8:0] dy;
    logic signed [8:0] dx;
    logic [8:0]        ady;
    logic [8:0]        adx;

    assign dy  = $signed({1'b0, car_y[g]}) - $signed(9'(PLAYER_Y));
    assign dx  = $signed({1'b0, player_x}) - $signed({1'b0, LX});
    assign ady = dy[8] ? 9'(-dy) : 9'(dy);
    assign adx = dx[8] ? 9'(-dx) : 9'(dx);

    assign hit_vec[g]    = car_active[g] && (ady < 9'(CAR_H)) && (adx < 9'(CAR_W));
    assign y_adv[g]      = {1'b0, car_y[g]} + step;
    assign retire_vec[g] = car_active[g] && (y_adv[g] > 9'(Y_MAX));
  end

  // Spawn choice, player move and score update for a non-colliding RUN frame.
  always_comb begin
    spawn_vec  = '0;
    px_next    = player_x;
    retire_cnt = '0;

    // The non-zero guard is redundant for a healthy LFSR but keeps all state bits in use.
    for (int i = 0; i < NUM_CARS; i++) begin
      if ((lfsr_q[2:0] == 3'(i)) && !car_active[i] && (|lfsr_q)) spawn_vec[i] = 1'b1;
      retire_cnt = retire_cnt + 3'(retire_vec[i]);
    end

    if (btn_sync[0] && !btn_sync[1]) begin
      if ({1'b0, player_x} < 9'(ROAD_MIN + PLAYER_STEP)) px_next = 8'(ROAD_MIN);
      else                                                px_next = player_x - 8'(PLAYER_STEP);
    end else if (btn_sync[1] && !btn_sync[0]) begin
      if ({1'b0, player_x} + 9'(PLAYER_STEP) > 9'(ROAD_MAX)) px_next = 8'(ROAD_MAX);
      else                                                    px_next = player_x + 8'(PLAYER_STEP);
    end

    score_sum  = {1'b0, score} + 17'(retire_cnt);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Game FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      btn_meta   <= '0;
      btn_sync   <= '0;
      start_d    <= 1'b0;
      crash_cnt  <= '0;
      player_x   <= 8'(PLAYER_X0);
      car_active <= '0;
      crash      <= 1'b0;
      running    <= 1'b0;
      score      <= '0;
      for (int i = 0; i < NUM_CARS; i++) car_y[i] <= '0;
    end else begin
      btn_meta <= {btn_start, btn_right, btn_left};
      btn_sync <= btn_meta;
      start_d  <= btn_sync[2];

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= RUN;
            running <= 1'b1;
            score   <= '0;
          end
        end

        RUN: begin
          if (frame_tick) begin
            if (|hit_vec) begin
              // Freeze everything on the crash frame.
              state     <= CRASH;
              crash     <= 1'b1;
              running   <= 1'b0;
              crash_cnt <= '0;
            end else begin
              player_x <= px_next;
              score    <= score_next;
              // A retiring car was active at frame start, so it cannot also spawn.
              for (int i = 0; i < NUM_CARS; i++) begin
                if (retire_vec[i]) begin
                  car_active[i] <= 1'b0;
                  car_y[i]      <= '0;
                end else if (car_active[i]) begin
                  car_y[i] <= y_adv[i][7:0];
                end else if (spawn_vec[i]) begin
                  car_active[i] <= 1'b1;
                  car_y[i]      <= '0;
                end
              end
            end
          end
        end

        CRASH: begin
          if (frame_tick) begin
            if (crash_cnt == CNT_W'(CRASH_FRAMES - 1)) begin
              state      <= IDLE;
              crash      <= 1'b0;
              crash_cnt  <= '0;
              player_x   <= 8'(PLAYER_X0);
              car_active <= '0;
              for (int i = 0; i < NUM_CARS; i++) car_y[i] <= '0;
            end else begin
              crash_cnt <= crash_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
